// File: rtl/feedforward_pkg.sv
// feedforward_pkg: shared FP32 constants, FSM state type and field helpers
// for the feedforward neuron and its fp32_mac datapath.
package feedforward_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int          BIAS  = 127;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP32_NINF = 32'hFF80_0000;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  function automatic logic fp32_is_nan(input logic [31:0] v);
    return (v[MAN_W +: EXP_W] == '1) && (v[MAN_W-1:0] != '0);
  endfunction

  function automatic logic fp32_is_inf(input logic [31:0] v);
    return (v[MAN_W +: EXP_W] == '1) && (v[MAN_W-1:0] == '0);
  endfunction

  // Zero exponent covers subnormals too: they are flushed to signed zero.
  function automatic logic fp32_is_zero(input logic [31:0] v);
    return v[MAN_W +: EXP_W] == '0;
  endfunction

endpackage

// File: rtl/feedforward_fp32_mac.sv
// fp32_mac: purely combinational FP32 y = a*b + c.
// Product and sum are each truncated (round toward zero). Subnormal inputs
// and results flush to signed zero, exponent overflow gives signed infinity,
// NaN / inf*0 / inf-inf give the canonical quiet NaN, exact cancellation +0.
// Ports: a, b, c (FP32 operands), y (FP32 result).
module fp32_mac
  import feedforward_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [31:0] y
);

  // ---------------- product stage (a*b, truncated to FP32) ----------------
  logic [47:0]        w_ma, w_mb, w_pm;
  logic signed [10:0] w_pe;
  logic [22:0]        w_pman;
  logic               w_ps;
  logic [31:0]        w_p;

  always_comb begin
    w_ps   = a[31] ^ b[31];
    w_ma   = {24'b0, 1'b1, a[MAN_W-1:0]};
    w_mb   = {24'b0, 1'b1, b[MAN_W-1:0]};
    w_pm   = w_ma * w_mb;
    w_pe   = $signed({3'b000, a[MAN_W +: EXP_W]}) + $signed({3'b000, b[MAN_W +: EXP_W]})
           - $signed(11'(BIAS)) + $signed({10'b0, w_pm[47]});
    w_pman = w_pm[47] ? w_pm[46:24] : w_pm[45:23];

    if (fp32_is_nan(a) || fp32_is_nan(b) ||
        (fp32_is_inf(a) && fp32_is_zero(b)) || (fp32_is_zero(a) && fp32_is_inf(b)))
      w_p = FP32_QNAN;
    else if (fp32_is_inf(a) || fp32_is_inf(b))
      w_p = w_ps ? FP32_NINF : FP32_PINF;
    else if (fp32_is_zero(a) || fp32_is_zero(b))
      w_p = {w_ps, FP32_ZERO[30:0]};
    else if (w_pe >= 11'sd255)
      w_p = w_ps ? FP32_NINF : FP32_PINF;
    else if (w_pe <= 11'sd0)
      w_p = {w_ps, FP32_ZERO[30:0]};
    else
      w_p = {w_ps, w_pe[7:0], w_pman};
  end

  // ---------------- sum stage (p + c, truncated to FP32) ----------------
  // 26 extra low bits keep the aligned sum exact whenever the exponent gap is
  // <= 26; beyond that the smaller operand only matters as a nonzero sticky
  // LSB, which is enough for truncation to land in the right bucket.
  logic [31:0]        w_big, w_sml;
  logic [7:0]         w_d;
  logic [49:0]        w_bm, w_sm;
  logic [50:0]        w_sum, w_norm;
  logic [5:0]         w_lead;
  logic signed [10:0] w_re;

  always_comb begin
    if (c[30:0] > w_p[30:0]) begin
      w_big = c;
      w_sml = w_p;
    end else begin
      w_big = w_p;
      w_sml = c;
    end
    w_d   = w_big[MAN_W +: EXP_W] - w_sml[MAN_W +: EXP_W];
    w_bm  = {1'b1, w_big[MAN_W-1:0], 26'b0};
    w_sm  = (w_d > 8'd26) ? 50'd1 : ({1'b1, w_sml[MAN_W-1:0], 26'b0} >> w_d);
    w_sum = (w_big[31] ^ w_sml[31]) ? ({1'b0, w_bm} - {1'b0, w_sm})
                                    : ({1'b0, w_bm} + {1'b0, w_sm});
    w_lead = '0;
    for (int unsigned i = 0; i < 51; i++) begin
      if (w_sum[i]) w_lead = 6'(i);
    end
    w_re   = $signed({3'b000, w_big[MAN_W +: EXP_W]}) + $signed({5'b0, w_lead}) - 11'sd49;
    w_norm = w_sum << (6'd50 - w_lead);
  end

  always_comb begin
    if (fp32_is_nan(w_p) || fp32_is_nan(c))
      y = FP32_QNAN;
    else if (fp32_is_inf(w_p) && fp32_is_inf(c))
      y = (w_p[31] != c[31]) ? FP32_QNAN : w_p;
    else if (fp32_is_inf(w_p))
      y = w_p;
    else if (fp32_is_inf(c))
      y = c;
    else if (fp32_is_zero(w_p) && fp32_is_zero(c))
      y = {w_p[31] & c[31], FP32_ZERO[30:0]};
    else if (fp32_is_zero(w_p))
      y = c;
    else if (fp32_is_zero(c))
      y = w_p;
    else if (w_sum == '0)
      y = FP32_ZERO;
    else if (w_re >= 11'sd255)
      y = w_big[31] ? FP32_NINF : FP32_PINF;
    else if (w_re <= 11'sd0)
      y = {w_big[31], FP32_ZERO[30:0]};
    else
      y = {w_big[31], w_re[7:0], w_norm[49:27]};
  end

endmodule

// File: rtl/feedforward_neuron.sv
// feedforward_neuron: FP32 neuron, result = f(bias + sum x[i]*w[i]), with one
// shared fp32_mac stepping through the N_INPUTS lanes, one term per cycle.
// Optional ReLU output stage enabled by macro FEEDFORWARD_RELU_EN.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operand handshake; in_ready high only while idle
//   x, w            packed lanes, lane i at [32*i +: 32]
//   bias            FP32 bias, loaded as the accumulator start value
//   result          FP32 output, held until the next done
//   done            one-cycle pulse, result valid in that cycle
//   busy            high while accumulating or writing the result
module feedforward_neuron
  import feedforward_pkg::*;
#(
  parameter  int unsigned N_INPUTS = 4,
  localparam int unsigned IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_INPUTS*32-1:0] x,
  input  logic [N_INPUTS*32-1:0] w,
  input  logic [31:0]           bias,
  output logic [31:0]           result,
  output logic                  done,
  output logic                  busy
);

  state_t                       r_state, w_state_nxt;
  logic [N_INPUTS-1:0][31:0]    r_x, r_w;
  logic [31:0]                  r_acc, r_result;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_done;
  logic                         w_accept, w_last;
  logic [31:0]                  w_x_lane, w_w_lane, w_mac_y, w_act;

  assign w_last = (r_idx == IDX_W'(N_INPUTS - 1));

  // lane select as an explicit mux so any N_INPUTS (incl. 1) indexes cleanly
  always_comb begin
    w_x_lane = '0;
    w_w_lane = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_x_lane = r_x[i];
        w_w_lane = r_w[i];
      end
    end
  end

  fp32_mac u_mac (
    .a (w_x_lane),
    .b (w_w_lane),
    .c (r_acc),
    .y (w_mac_y)
  );

`ifdef FEEDFORWARD_RELU_EN
  assign w_act = (r_acc[31] && !fp32_is_nan(r_acc)) ? FP32_ZERO : r_acc;
`else
  assign w_act = r_acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = OUT;
      end
      OUT: begin
        busy        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_w      <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x   <= x;
            r_w   <= w;
            r_acc <= bias;
            r_idx <= '0;
          end
        end
        MAC: begin
          r_acc <= w_mac_y;
          r_idx <= r_idx + IDX_W'(1);
        end
        OUT: begin
          r_result <= w_act;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: tb/tb_feedforward_neuron.sv
`timescale 1ns/1ps
module tb_feedforward_neuron;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, done, busy;
  logic [127:0] x, w;
  logic [31:0]  bias, result;
  logic         in_valid1, in_ready1, done1, busy1;
  logic [31:0]  x1, w1, bias1, result1;
  logic [31:0]  ua, ub, uc, uy;

  feedforward_neuron #(.N_INPUTS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w(w), .bias(bias), .result(result), .done(done), .busy(busy));

  feedforward_neuron #(.N_INPUTS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .x(x1), .w(w1), .bias(bias1), .result(result1), .done(done1), .busy(busy1));

  fp32_mac u_unit (.a(ua), .b(ub), .c(uc), .y(uy));

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] res; int unsigned when; } exp_t;
  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;

`ifdef FEEDFORWARD_RELU_EN
  localparam logic [31:0] NEG5_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] NEG5_EXP = 32'hC0A0_0000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  task automatic chk_int(input string name, input int unsigned act, input int unsigned expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // ---------------- reference model: exact real arithmetic + truncation ----------------
  function automatic real f2r(input logic [31:0] v);
    logic [63:0] d;
    if (v[30:23] == 8'd0) return 0.0;
    d = {v[31], 11'(int'(v[30:23]) - 127 + 1023), v[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'h0;
    e = int'(d[62:52]) - 1023 + 127;
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0)   return {d[63], 31'h0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] model(input logic [127:0] xv, input logic [127:0] wv,
                                        input logic [31:0] bv, input int n);
    logic [31:0] acc, p;
    acc = bv;
    for (int i = 0; i < n; i++) begin
      p   = r2f(f2r(xv[32*i +: 32]) * f2r(wv[32*i +: 32]));
      acc = r2f(f2r(acc) + f2r(p));
    end
`ifdef FEEDFORWARD_RELU_EN
    if (acc[31] && !(acc[30:23] == 8'hFF && acc[22:0] != 23'h0)) acc = 32'h0;
`endif
    return acc;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(124, 130));
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (done) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL n4_spurious_done: got done=1 at cycle %0d expected no pending bundle", cyc);
      end else begin
        e4 = q4.pop_front();
        chk("n4_result", result, e4.res);
        chk_int("n4_done_cycle", cyc, e4.when);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL n1_spurious_done: got done=1 at cycle %0d expected no pending bundle", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("n1_result", result1, e1.res);
        chk_int("n1_done_cycle", cyc, e1.when);
      end
    end
  end

  int unsigned busy_run = 0;
  bit          abort = 1'b0;
  always @(negedge clk) begin
    if (busy) busy_run <= busy_run + 1;
    else begin
      if (busy_run != 0 && !abort) chk_int("n4_busy_len", busy_run, 5);
      busy_run <= 0;
    end
  end

  // ---------------- drivers ----------------
  task automatic send4(input logic [127:0] xv, input logic [127:0] wv,
                       input logic [31:0] bv, input logic [31:0] expv);
    int unsigned t = 0;
    x = xv; w = wv; bias = bv; in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL n4_accept_timeout: got in_ready=0 expected 1");
    end else begin
      q4.push_back('{expv, cyc + 6});
    end
    @(negedge clk);
  endtask

  task automatic send1(input logic [31:0] xv, input logic [31:0] wv,
                       input logic [31:0] bv, input logic [31:0] expv);
    int unsigned t = 0;
    x1 = xv; w1 = wv; bias1 = bv; in_valid1 = 1'b1;
    while (!in_ready1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready1) begin
      checks++; errors++;
      $display("FAIL n1_accept_timeout: got in_ready=0 expected 1");
    end else begin
      q1.push_back('{expv, cyc + 3});
    end
    @(negedge clk);
  endtask

  task automatic wait_empty(input string name);
    int unsigned t = 0;
    while ((q4.size() != 0 || q1.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q4.size() != 0 || q1.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s: got %0d results outstanding expected 0", name, q4.size() + q1.size());
    end
  endtask

  logic [127:0] xa, wa, half, x1234;
  logic [31:0]  ba;

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; w = '0; bias = '0;
    in_valid1 = 1'b0; x1 = '0; w1 = '0; bias1 = '0;
    ua = '0; ub = '0; uc = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_n1_result", result1, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // direct datapath vectors: a, b, c -> y
    begin
      logic [31:0] vec [13][4];
      vec = '{
        '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000},  // exact cancel -> +0
        '{32'h7F800000, 32'h00000000, 32'h00000000, 32'h7FC00000},  // inf*0
        '{32'h7F000000, 32'h7F000000, 32'h00000000, 32'h7F800000},  // product overflow
        '{32'hFF000000, 32'h7F000000, 32'h00000000, 32'hFF800000},  // negative overflow
        '{32'h00800000, 32'h00800000, 32'h00000000, 32'h00000000},  // underflow
        '{32'h80800000, 32'h00800000, 32'h80000000, 32'h80000000},  // -0 + -0
        '{32'h3F800000, 32'h3F800000, 32'h00000001, 32'h3F800000},  // subnormal c flushed
        '{32'h3F800000, 32'h3F800000, 32'hB3000000, 32'h3F7FFFFF},  // sum truncates
        '{32'h3FC00001, 32'h3FC00001, 32'h00000000, 32'h40100001},  // product truncates
        '{32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h7FC00000},  // inf - inf
        '{32'h7FC00000, 32'h3F800000, 32'h3F800000, 32'h7FC00000},  // NaN input
        '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000},  // sum overflow
        '{32'h3F800000, 32'h3F800000, 32'hB0800000, 32'h3F7FFFFF}   // far-aligned sticky
      };
      for (int i = 0; i < 13; i++) begin
        ua = vec[i][0]; ub = vec[i][1]; uc = vec[i][2];
        #1;
        chk($sformatf("mac_vec%0d", i), uy, vec[i][3]);
      end
    end

    // directed neuron bundles
    x1234 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    half  = {4{32'h3F000000}};
    send4(x1234, half, 32'h0, 32'h40A00000);
    in_valid = 1'b0; repeat (8) @(negedge clk);
    send4(x1234, half, 32'h3F800000, 32'h40C00000);
    in_valid = 1'b0; repeat (8) @(negedge clk);
    send4(x1234, {4{32'hBF000000}}, 32'h0, NEG5_EXP);
    in_valid = 1'b0; repeat (8) @(negedge clk);
    send4({x1234[127:32], 32'h7FC00000}, half, 32'h0, 32'h7FC00000);
    in_valid = 1'b0; repeat (8) @(negedge clk);

    // two bundles with in_valid held: second accepted in the done cycle
    for (int k = 0; k < 2; k++) begin
      xa = {rand_fp(), rand_fp(), rand_fp(), rand_fp()};
      wa = {rand_fp(), rand_fp(), rand_fp(), rand_fp()};
      ba = rand_fp();
      send4(xa, wa, ba, model(xa, wa, ba, 4));
    end
    in_valid = 1'b0;
    wait_empty("b2b_drain");

    // reset during MAC: the pending bundle is abandoned
    send4(x1234, half, 32'h0, 32'h40A00000);
    in_valid = 1'b0;
    abort = 1'b1;
    void'(q4.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'h1);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    repeat (10) @(negedge clk);
    abort = 1'b0;

    // randomized traffic, mixing back-to-back and idle gaps with bus noise
    for (int k = 0; k < 24; k++) begin
      xa = {rand_fp(), rand_fp(), rand_fp(), rand_fp()};
      wa = {rand_fp(), rand_fp(), rand_fp(), rand_fp()};
      ba = rand_fp();
      send4(xa, wa, ba, model(xa, wa, ba, 4));
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        x = {$urandom, $urandom, $urandom, $urandom};
        w = {$urandom, $urandom, $urandom, $urandom};
        bias = $urandom;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    wait_empty("rand_drain");

    // single-lane instance
    send1(32'h40000000, 32'h40400000, 32'h0, 32'h40C00000);
    in_valid1 = 1'b0; repeat (4) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      xa = {96'b0, rand_fp()};
      wa = {96'b0, rand_fp()};
      ba = rand_fp();
      send1(xa[31:0], wa[31:0], ba, model(xa, wa, ba, 1));
    end
    in_valid1 = 1'b0;
    wait_empty("n1_drain");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/feedforward_neuron.md
Name: feedforward_neuron

Overview:
- Parametrised successor to the fixed 4-input feedforward unit: one IEEE-754 single-precision neuron computing result = bias + sum(x[i]*w[i]) over N_INPUTS lanes.
- Sequential: a single shared multiply-add datapath is time-multiplexed over the inputs, one term per cycle.
- Adds a valid/ready input handshake, a bias term, a busy flag and an optional ReLU.
- Sits between the layer controller, which supplies operand vectors, and the next layer's input buffer.

Parameters:
- N_INPUTS, 4, number of x/w pairs per evaluation; legal values are 1 to 256.
- IDX_W, $clog2(N_INPUTS) with a minimum of 1, lane index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle; high only in IDLE.
- x  in  N_INPUTS*32  packed inputs; lane i is x[32*i +: 32].
- w  in  N_INPUTS*32  packed weights, same lane layout as x.
- bias  in  32  FP32 bias.
- result  out  32  FP32 neuron output; holds its value until the next done.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- busy  out  1  high in MAC and OUT states.

Behaviour:
- Reset values: result=0x00000000, done=0, busy=0, in_ready=1, state=IDLE, acc=0, idx=0.
- States:
  - IDLE: in_ready=1. When in_valid & in_ready, capture x, w and bias into registers, set acc<=bias and idx<=0, go to MAC.
  - MAC: on each edge, acc <= fp32_mac(x_r[idx], w_r[idx], acc) and idx <= idx+1. When idx==N_INPUTS-1, go to OUT.
  - OUT: result <= f(acc), done <= 1, go to IDLE.
- Latency: if a bundle is accepted at edge k, done is high in the cycle after edge k+N_INPUTS+1. Throughput is one bundle every N_INPUTS+2 cycles.
- Back-to-back: a new bundle may be accepted in the same cycle that done is high, because the block is in IDLE.
- Input bus changes after acceptance have no effect; operands are registered.
- N_INPUTS=1: MAC lasts exactly one cycle.
- fp32_mac arithmetic:
  - Product and sum are each rounded toward zero, giving two roundings.
  - Subnormal inputs and results flush to signed zero.
  - Exponent overflow gives signed infinity.
  - Any NaN input, inf*0, or +inf + -inf gives 0x7FC00000.
  - Exact cancellation gives +0.
- rst mid-operation: abort on the next edge, restore all reset values, and do not pulse done.
- in_valid while busy is ignored; the upstream must hold the bundle until in_ready.

Optional Feature:
- Macro: FEEDFORWARD_RELU_EN.
- Defined: f(acc)=0x00000000 when acc[31]=1 and acc is not NaN. -0 maps to +0. NaN passes through unchanged.
- Undefined: f(acc)=acc (linear output), identical to the non-activated behaviour.

Decomposition:
- Package feedforward_pkg:
  - FP32 field constants: EXP_W=8, MAN_W=23, BIAS=127.
  - Special values: FP32_QNAN=0x7FC00000, FP32_ZERO, FP32_PINF, FP32_NINF.
  - State typedef {IDLE, MAC, OUT}.
- Sub-module fp32_mac: purely combinational a*b+c, ports a, b, c, y. It is unit-tested on its own; the neuron instantiates it once.

Test Plan:
- N=4; x={1.0,2.0,3.0,4.0} (0x3F800000, 0x40000000, 0x40400000, 0x40800000); w all 0.5 (0x3F000000); bias 0 -> result 0x40A00000 (5.0); done exactly 6 cycles after the accept edge; busy high for 5 cycles.
- Same operands, bias 1.0 (0x3F800000) -> result 0x40C00000 (6.0).
- Weights all -0.5 (0xBF000000), bias 0 -> 0xC0A00000 without FEEDFORWARD_RELU_EN; 0x00000000 with it.
- x0=0x7FC00000 (NaN), other lanes as in the first scenario -> 0x7FC00000 in both builds.
- Two bundles with in_valid held high -> second accepted in the done cycle; two done pulses 6 cycles apart; rst asserted during MAC -> no done, in_ready=1 the cycle after rst.
- N_INPUTS=1; x=2.0, w=3.0 (0x40400000), bias 0 -> result 0x40C00000, done 3 cycles after accept.
